// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the proc2mem/mem2proc bus. It accepts loads and
//   stores and tags each accepted request with a nonzero tag that runs
//   1..15 and then wraps to 1. Load data is returned in order after a fixed
//   latency, and each return is visible for exactly one cycle.
//
// Optional build macro:
//   MEM_RESP_STALL_EN - an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5) rejects any
//                       request seen while lfsr[1:0] == 2'b00.
//
// Ports:
//   clock             system clock, rising edge
//   reset_n           asynchronous active-low reset
//   proc2mem_command  0 none, 1 load, 2 store, 3 reserved (treated as none)
//   proc2mem_addr     byte address; bits [2:0] are ignored, word index wraps
//   proc2mem_data     store data
//   mem2proc_response tag of the request accepted this cycle, 0 = none/rejected
//   mem2proc_data     load return data, valid when mem2proc_tag != 0
//   mem2proc_tag      tag of the returning load, 0 = no return
//   outstanding       number of loads in flight
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int DEPTH     = 8,
  parameter int MEM_WORDS = 1024,
  parameter int XLEN      = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [1:0]                   proc2mem_command,
  input  logic [XLEN-1:0]              proc2mem_addr,
  input  logic [63:0]                  proc2mem_data,
  output logic [3:0]                   mem2proc_response,
  output logic [63:0]                  mem2proc_data,
  output logic [3:0]                   mem2proc_tag,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CD_INIT  = CW'(LATENCY-1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
  localparam logic [OW-1:0] CNT_FULL = OW'(DEPTH);

  logic [63:0]   storage [MEM_WORDS];
  logic [3:0]    tag_q   [DEPTH];
  logic [63:0]   data_q  [DEPTH];
  logic [CW-1:0] cd_q    [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] count;
  logic [3:0]    next_tag;
  logic [AW-1:0] word;
  logic          is_load, is_store, full, pop, stall, accept, push;

  assign word = proc2mem_addr[3 +: AW];

`ifdef MEM_RESP_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr <= 8'hA5;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Response path is combinational. A full FIFO can still take a load when
  // the head retires on the same edge.
  always_comb begin
    is_load           = (proc2mem_command == 2'd1);
    is_store          = (proc2mem_command == 2'd2);
    full              = (count == CNT_FULL);
    pop               = (count != '0) && (cd_q[rd_ptr] == '0);
    accept            = reset_n && !stall &&
                        ((is_load && (!full || pop)) || is_store);
    push              = accept && is_load;
    mem2proc_response = accept ? next_tag : 4'd0;
  end

  always_ff @(posedge clock) begin
    if (accept && is_store) storage[word] <= proc2mem_data;
  end

  // The payload is not reset. Entries are only qualified through count and
  // the pointers. On a push the countdown load overrides the decrement.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cd_q[i] != '0) cd_q[i] <= cd_q[i] - CW'(1);
    end
    if (push) begin
      tag_q[wr_ptr]  <= next_tag;
      data_q[wr_ptr] <= storage[word];
      cd_q[wr_ptr]   <= CD_INIT;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      next_tag      <= 4'd1;
      mem2proc_tag  <= 4'd0;
      mem2proc_data <= 64'd0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);

      if (push && !pop)      count <= count + OW'(1);
      else if (pop && !push) count <= count - OW'(1);

      if (accept) next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;

      if (pop) begin
        mem2proc_tag  <= tag_q[rd_ptr];
        mem2proc_data <= data_q[rd_ptr];
      end else begin
        mem2proc_tag  <= 4'd0;
        mem2proc_data <= 64'd0;
      end
    end
  end

  assign outstanding = count;

endmodule
